// File: rtl/execute_unit_if.sv
// rtl/execute_unit_if.sv - issue/result handshake bundle between decode, execute and writeback
interface execute_unit_if #(
  parameter int WIDTH = 8
);
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] primary_value;
  logic [WIDTH-1:0] secondary_value;
  logic [2:0]       dest_select;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] product_high;
  logic [2:0]       result_dest;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output issue_valid, opcode, primary_value, secondary_value, dest_select, result_ready,
    input  issue_ready, result_valid, result, product_high, result_dest, flags, busy
  );

  modport slave (
    input  issue_valid, opcode, primary_value, secondary_value, dest_select, result_ready,
    output issue_ready, result_valid, result, product_high, result_dest, flags, busy
  );
endinterface

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - 8-bit ALU execute stage with one-entry result register
// Iterative 8x8 multiplier built only when ALU_MULTIPLY_EN is defined.
module execute_unit (
  input  logic          clock,
  input  logic          reset,
  execute_unit_if.slave eu
);
  localparam logic [3:0] OP_ADD = 4'd1,  OP_ADC = 4'd2,  OP_SUB = 4'd3,  OP_SBC = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,  OP_NOT = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_ROL = 4'd11, OP_ROR = 4'd12;
  localparam logic [3:0] OP_INC = 4'd13, OP_DEC = 4'd14, OP_MUL = 4'd15;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t     state_q, state_d;
  logic [7:0] result_q, result_d;
  logic [2:0] dest_q, dest_d;
  logic [3:0] flags_q, flags_d;
  logic       valid_q, valid_d;
  logic       issue_ready, accept;
  logic [7:0] a, ob, alu_r;
  logic [8:0] arith;
  logic       cin, alu_c, alu_v, alu_load;

  assign a           = eu.primary_value;
  assign cin         = flags_q[1];
  assign issue_ready = (state_q == S_IDLE) && (!valid_q || eu.result_ready);
  assign accept      = eu.issue_valid && issue_ready;

  // arith[8] is carry for additions and borrow for subtractions
  always_comb begin
    ob       = eu.secondary_value;
    arith    = 9'd0;
    alu_r    = 8'd0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_load = 1'b1;
    case (eu.opcode)
      OP_ADD, OP_ADC, OP_INC: begin
        if (eu.opcode == OP_INC) ob = 8'd1;
        arith = {1'b0, a} + {1'b0, ob} + {8'd0, (eu.opcode == OP_ADC) && cin};
        alu_r = arith[7:0];
        alu_c = arith[8];
        alu_v = (a[7] == ob[7]) && (alu_r[7] != a[7]);
      end
      OP_SUB, OP_SBC, OP_DEC: begin
        if (eu.opcode == OP_DEC) ob = 8'd1;
        arith = {1'b0, a} - {1'b0, ob} - {8'd0, (eu.opcode == OP_SBC) && cin};
        alu_r = arith[7:0];
        alu_c = arith[8];
        alu_v = (a[7] != ob[7]) && (alu_r[7] != a[7]);
      end
      OP_AND: alu_r = a & ob;
      OP_OR:  alu_r = a | ob;
      OP_XOR: alu_r = a ^ ob;
      OP_NOT: alu_r = ~a;
      OP_SHL: begin alu_r = {a[6:0], 1'b0}; alu_c = a[7]; end
      OP_SHR: begin alu_r = {1'b0, a[7:1]}; alu_c = a[0]; end
      OP_ROL: begin alu_r = {a[6:0], a[7]}; alu_c = a[7]; end
      OP_ROR: begin alu_r = {a[0], a[7:1]}; alu_c = a[0]; end
      default: alu_load = 1'b0;
    endcase
  end

`ifdef ALU_MULTIPLY_EN
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d, acc_step;
  logic [7:0]  mcand_q, mcand_d, mplier_q, mplier_d, prod_hi_q, prod_hi_d;

  assign acc_step = acc_q + (mplier_q[cnt_q] ? ({8'd0, mcand_q} << cnt_q) : 16'd0);
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    dest_d   = dest_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
`ifdef ALU_MULTIPLY_EN
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_hi_d = prod_hi_q;
`endif
    if (eu.result_ready) valid_d = 1'b0;
    if (accept && alu_load) begin
      result_d = alu_r;
      dest_d   = eu.dest_select;
      flags_d  = {alu_r == 8'd0, alu_r[7], alu_c, alu_v};
      valid_d  = 1'b1;
`ifdef ALU_MULTIPLY_EN
      prod_hi_d = 8'd0;
`endif
    end
`ifdef ALU_MULTIPLY_EN
    case (state_q)
      S_IDLE: begin
        if (accept && eu.opcode == OP_MUL) begin
          state_d  = S_MUL;
          cnt_d    = 3'd0;
          acc_d    = 16'd0;
          mcand_d  = eu.primary_value;
          mplier_d = eu.secondary_value;
          dest_d   = eu.dest_select;
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = S_IDLE;
          result_d  = acc_step[7:0];
          prod_hi_d = acc_step[15:8];
          flags_d   = {acc_step == 16'd0, acc_step[15], |acc_step[15:8], |acc_step[15:8]};
          valid_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      result_q <= 8'd0;
      dest_q   <= 3'd0;
      flags_q  <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dest_q   <= dest_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

`ifdef ALU_MULTIPLY_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= 3'd0;
      acc_q     <= 16'd0;
      mcand_q   <= 8'd0;
      mplier_q  <= 8'd0;
      prod_hi_q <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_hi_q <= prod_hi_d;
    end
  end

  assign eu.busy         = (state_q == S_MUL);
  assign eu.product_high = prod_hi_q;
`else
  assign eu.busy         = 1'b0;
  assign eu.product_high = 8'd0;
`endif

  assign eu.issue_ready  = issue_ready;
  assign eu.result_valid = valid_q;
  assign eu.result       = result_q;
  assign eu.result_dest  = dest_q;
  assign eu.flags        = flags_q;
endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - self-checking bench for execute_unit (table, corner sequences, random vs model)
module tb_execute_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  execute_unit_if bus ();
  execute_unit dut (.clock(clock), .reset(reset), .eu(bus));

`ifdef ALU_MULTIPLY_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] d;
    logic       e_valid;
    logic [7:0] e_r;
    logic [7:0] e_ph;
    logic [2:0] e_d;
    logic [3:0] e_f;
  } vec_t;

  vec_t tv [16];
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_r, m_ph;
  logic [2:0] m_d;
  logic [3:0] m_f;
  logic       m_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r = 8'd0; m_ph = 8'd0; m_d = 3'd0; m_f = 4'd0; m_v = 1'b0;
  endtask

  // Reference behaviour from plain integer arithmetic
  task automatic model(input int op, input int a, input int b, input int d);
    int r, ph, c, v, s, sa, sb, ci, p, bb;
    bit prod, z, n;
    ci = m_f[1];
    bb = b;
    r = 0; ph = 0; c = 0; v = 0; p = 0; prod = 1'b1;
    if (op == 13 || op == 14) bb = 1;
    sa = (a > 127) ? a - 256 : a;
    sb = (bb > 127) ? bb - 256 : bb;
    case (op)
      1, 2, 13: begin
        if (op != 2) ci = 0;
        s = a + bb + ci; r = s % 256; c = (s > 255);
        s = sa + sb + ci; v = (s > 127 || s < -128);
      end
      3, 4, 14: begin
        if (op != 4) ci = 0;
        s = a - bb - ci; c = (s < 0); r = (s + 256) % 256;
        s = sa - sb - ci; v = (s > 127 || s < -128);
      end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = 255 - a;
      9: begin r = (a * 2) % 256; c = a / 128; end
      10: begin r = a / 2; c = a % 2; end
      11: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
      12: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      15: begin
        if (MUL_EN) begin
          p = a * b; r = p % 256; ph = p / 256; c = (ph != 0); v = c;
        end else prod = 1'b0;
      end
      default: prod = 1'b0;
    endcase
    m_v = prod;
    if (prod) begin
      z = (op == 15) ? (p == 0) : (r == 0);
      n = (op == 15) ? (p >= 32768) : (r >= 128);
      m_r = r[7:0]; m_ph = ph[7:0]; m_d = d[2:0];
      m_f = {z, n, c[0], v[0]};
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, bus.result_valid, m_v);
    check({tag, "_result"}, bus.result, m_r);
    check({tag, "_phigh"}, bus.product_high, m_ph);
    check({tag, "_dest"}, bus.result_dest, m_d);
    check({tag, "_flags"}, bus.flags, m_f);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Present one op with result_ready high, return once its result (if any) is visible
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    int n;
    bus.opcode = op; bus.primary_value = a; bus.secondary_value = b; bus.dest_select = d;
    bus.issue_valid = 1'b1; bus.result_ready = 1'b1;
    #0;
    n = 0;
    while (!bus.issue_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (!bus.issue_ready) check("accept_timeout", bus.issue_ready, 1);
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
`ifdef ALU_MULTIPLY_EN
    if (op == 4'd15) begin
      check("mul_busy_start", bus.busy, 1);
      check("mul_ready_low", bus.issue_ready, 0);
      repeat (7) begin @(posedge clock); #1; end
      check("mul_busy_step7", bus.busy, 1);
      check("mul_no_early_valid", bus.result_valid, 0);
      @(posedge clock); #1;
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.issue_valid = 1'b0; bus.opcode = 4'd0; bus.primary_value = 8'd0;
    bus.secondary_value = 8'd0; bus.dest_select = 3'd0; bus.result_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    check_all("reset");
    check("reset_issue_ready", bus.issue_ready, 1);

    tv[0]  = '{4'd1,  8'h7F, 8'h01, 3'd2, 1'b1, 8'h80, 8'h00, 3'd2, 4'b0101};
    tv[1]  = '{4'd3,  8'h00, 8'h01, 3'd0, 1'b1, 8'hFF, 8'h00, 3'd0, 4'b0110};
    tv[2]  = '{4'd4,  8'h05, 8'h02, 3'd1, 1'b1, 8'h02, 8'h00, 3'd1, 4'b0000};
    tv[3]  = '{4'd7,  8'h5A, 8'h0F, 3'd3, 1'b1, 8'h55, 8'h00, 3'd3, 4'b0000};
    tv[4]  = '{4'd9,  8'h81, 8'h00, 3'd4, 1'b1, 8'h02, 8'h00, 3'd4, 4'b0010};
    tv[5]  = '{4'd12, 8'h01, 8'h00, 3'd5, 1'b1, 8'h80, 8'h00, 3'd5, 4'b0110};
`ifdef ALU_MULTIPLY_EN
    tv[6]  = '{4'd15, 8'hFF, 8'hFF, 3'd6, 1'b1, 8'h01, 8'hFE, 3'd6, 4'b0111};
`else
    tv[6]  = '{4'd15, 8'hFF, 8'hFF, 3'd6, 1'b0, 8'h80, 8'h00, 3'd5, 4'b0110};
`endif
    tv[7]  = '{4'd8,  8'h0F, 8'h00, 3'd7, 1'b1, 8'hF0, 8'h00, 3'd7, 4'b0100};
    tv[8]  = '{4'd13, 8'hFF, 8'h00, 3'd0, 1'b1, 8'h00, 8'h00, 3'd0, 4'b1010};
    tv[9]  = '{4'd2,  8'h7F, 8'h00, 3'd2, 1'b1, 8'h80, 8'h00, 3'd2, 4'b0101};
    tv[10] = '{4'd14, 8'h80, 8'h00, 3'd1, 1'b1, 8'h7F, 8'h00, 3'd1, 4'b0001};
    tv[11] = '{4'd11, 8'h80, 8'h00, 3'd3, 1'b1, 8'h01, 8'h00, 3'd3, 4'b0010};
    tv[12] = '{4'd0,  8'h12, 8'h34, 3'd4, 1'b0, 8'h01, 8'h00, 3'd3, 4'b0010};
    tv[13] = '{4'd10, 8'h01, 8'h00, 3'd4, 1'b1, 8'h00, 8'h00, 3'd4, 4'b1010};
    tv[14] = '{4'd5,  8'hF0, 8'h0F, 3'd5, 1'b1, 8'h00, 8'h00, 3'd5, 4'b1000};
    tv[15] = '{4'd6,  8'h30, 8'h03, 3'd6, 1'b1, 8'h33, 8'h00, 3'd6, 4'b0000};

    foreach (tv[i]) begin
      issue(tv[i].op, tv[i].a, tv[i].b, tv[i].d);
      check($sformatf("tv%0d_valid", i), bus.result_valid, tv[i].e_valid);
      check($sformatf("tv%0d_result", i), bus.result, tv[i].e_r);
      check($sformatf("tv%0d_phigh", i), bus.product_high, tv[i].e_ph);
      check($sformatf("tv%0d_dest", i), bus.result_dest, tv[i].e_d);
      check($sformatf("tv%0d_flags", i), bus.flags, tv[i].e_f);
      check($sformatf("tv%0d_busy", i), bus.busy, 0);
    end

    // Backpressure: result held, no accepts, then drain and refill on one edge
    do_reset();
    bus.opcode = 4'd1; bus.primary_value = 8'h01; bus.secondary_value = 8'h02; bus.dest_select = 3'd1;
    bus.issue_valid = 1'b1; bus.result_ready = 1'b0;
    @(posedge clock); #1;
    model(1, 8'h01, 8'h02, 1);
    check_all("bp_load");
    bus.opcode = 4'd3; bus.primary_value = 8'h09; bus.secondary_value = 8'h04; bus.dest_select = 3'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check($sformatf("bp_hold%0d_ready", k), bus.issue_ready, 0);
      check_all($sformatf("bp_hold%0d", k));
    end
    bus.result_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.issue_ready, 1);
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    model(3, 8'h09, 8'h04, 3);
    check_all("bp_refill");

    // Reset in the middle of a multiply
    bus.opcode = 4'd15; bus.primary_value = 8'hFF; bus.secondary_value = 8'hFF; bus.dest_select = 3'd6;
    bus.issue_valid = 1'b1; bus.result_ready = 1'b1;
    @(posedge clock); #1;
    bus.issue_valid = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
`ifdef ALU_MULTIPLY_EN
    check("rst_mul_busy_before", bus.busy, 1);
`endif
    do_reset();
    check_all("rst_mul");
    check("rst_mul_ready", bus.issue_ready, 1);
    repeat (10) begin @(posedge clock); #1; end
    check("rst_mul_quiet", bus.result_valid, 0);
    issue(4'd1, 8'h10, 8'h20, 3'd5);
    model(1, 8'h10, 8'h20, 5);
    check_all("post_rst_add");

    // Random ops against the reference model
    for (int k = 0; k < 250; k++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      logic [2:0] d;
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      d  = 3'($urandom_range(0, 7));
      issue(op, a, b, d);
      model(op, a, b, d);
      check_all($sformatf("rnd%0d_op%0d", k, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
